// File: rtl/hrange_share_if.sv
// hrange_share_if
//   Bundles every client-side and hrange-side signal of the shared hrange
//   arbiter so the arbiter, the two clients and the hrange instance meet on
//   one interface.
//   master : arbiter view. It drives the client outputs and the hrange controls.
//   slave  : environment view. Clients and hrange drive the arbiter inputs.
// Signals
//   req0/req1, base*/limit*/step*, _ready*   : client requests, arguments, ready
//   _valid*, _0_*, _1_*, _done*              : client tuple slot and done pulse
//   grant, last_beats                        : session owner and last beat count
//   hr_base/limit/step, hr_start/ready/reset : hrange arguments and controls
//   hr_0, hr_1, hr_valid, hr_done            : hrange tuple and status
interface hrange_share_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic                    req0, req1;
  logic signed [WIDTH-1:0] base0, limit0, step0;
  logic signed [WIDTH-1:0] base1, limit1, step1;
  logic                    _ready0, _ready1;
  logic                    _valid0, _valid1;
  logic signed [WIDTH-1:0] _0_0, _1_0, _0_1, _1_1;
  logic                    _done0, _done1;
  logic [1:0]              grant;
  logic [CNT_W-1:0]        last_beats;
  logic signed [WIDTH-1:0] hr_base, hr_limit, hr_step;
  logic                    hr_start, hr_ready, hr_reset;
  logic signed [WIDTH-1:0] hr_0, hr_1;
  logic                    hr_valid, hr_done;

  modport master (
    input  req0, req1, base0, limit0, step0, base1, limit1, step1,
    input  _ready0, _ready1, hr_0, hr_1, hr_valid, hr_done,
    output _valid0, _valid1, _0_0, _1_0, _0_1, _1_1, _done0, _done1,
    output grant, last_beats, hr_base, hr_limit, hr_step,
    output hr_start, hr_ready, hr_reset
  );

  modport slave (
    output req0, req1, base0, limit0, step0, base1, limit1, step1,
    output _ready0, _ready1, hr_0, hr_1, hr_valid, hr_done,
    input  _valid0, _valid1, _0_0, _1_0, _0_1, _1_1, _done0, _done1,
    input  grant, last_beats, hr_base, hr_limit, hr_step,
    input  hr_start, hr_ready, hr_reset
  );
endinterface

// File: rtl/hrange_share_arbiter.sv
// hrange_share_arbiter
//   Shares one hrange generator between two clients. Sessions are granted
//   round-robin. The owner's arguments are latched and hrange is launched.
//   Each tuple goes to the owner through a one-entry registered ready/valid
//   slot. The session closes with a one-cycle done pulse.
// Ports
//   _clock : clock
//   _reset : synchronous active-high reset, also forwarded to hrange as hr_reset
//   bus    : hrange_share_if master modport (client and hrange signals)
module hrange_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic            _clock,
  input logic            _reset,
  hrange_share_if.master bus
);
  typedef enum logic [1:0] {IDLE, LAUNCH, STREAM, FINISH} state_t;

  state_t                     state_reg, state_next;
  logic [1:0]                 grant_reg, grant_next;
  logic                       rr_reg, rr_next;       // client served last
  logic [1:0]                 valid_reg, valid_next;
  logic [1:0]                 done_reg, done_next;
  logic [1:0][WIDTH-1:0]      t0_reg, t0_next, t1_reg, t1_next;
  logic [WIDTH-1:0]           base_reg, base_next, limit_reg, limit_next;
  logic [WIDTH-1:0]           step_reg, step_next;
  logic                       start_reg, start_next;
  logic [CNT_W-1:0]           cnt_reg, cnt_next, last_reg, last_next;

  logic [1:0] req_vec, ready_vec;
  logic       g;            // index of the session owner
  logic       pick;         // client chosen when arbitrating
  logic       slot_free;    // owner slot empty or draining this cycle
  logic       hr_ready_int;

  assign req_vec   = {bus.req1, bus.req0};
  assign ready_vec = {bus._ready1, bus._ready0};
  assign g         = grant_reg[1];
  // When both clients request, the one not served last wins.
  assign pick      = (&req_vec) ? ~rr_reg : req_vec[1];
  assign slot_free = !valid_reg[g] || ready_vec[g];
  assign hr_ready_int = (state_reg == STREAM) && (grant_reg != 2'b00) && slot_free;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rr_next    = rr_reg;
    valid_next = valid_reg;
    done_next  = 2'b00;
    t0_next    = t0_reg;
    t1_next    = t1_reg;
    base_next  = base_reg;
    limit_next = limit_reg;
    step_next  = step_reg;
    start_next = start_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;

    // The owner's slot empties when it samples ready. A new beat in the same
    // cycle overrides the clear below.
    if (valid_reg[g] && ready_vec[g]) valid_next[g] = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          grant_next = pick ? 2'b10 : 2'b01;
          base_next  = pick ? bus.base1  : bus.base0;
          limit_next = pick ? bus.limit1 : bus.limit0;
          step_next  = pick ? bus.step1  : bus.step0;
          start_next = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        start_next = 1'b0;
        cnt_next   = '0;
        state_next = STREAM;
      end
      STREAM: begin
        // A tuple that arrives together with hr_done is dropped.
        if (bus.hr_done) begin
          state_next = FINISH;
        end else if (bus.hr_valid && hr_ready_int) begin
          t0_next[g]    = bus.hr_0;
          t1_next[g]    = bus.hr_1;
          valid_next[g] = 1'b1;
          if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
        end
      end
      FINISH: begin
        // Wait for the owner's last tuple to leave before signalling done.
        // This keeps done and valid apart.
        if (slot_free) begin
          done_next[g] = 1'b1;
          last_next    = cnt_reg;
          rr_next      = g;
          grant_next   = 2'b00;
          t0_next[g]   = '0;
          t1_next[g]   = '0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_reg <= IDLE;
      grant_reg <= 2'b00;
      rr_reg    <= 1'b1;        // client 0 wins the first contention
      valid_reg <= 2'b00;
      done_reg  <= 2'b00;
      t0_reg    <= '0;
      t1_reg    <= '0;
      base_reg  <= '0;
      limit_reg <= '0;
      step_reg  <= '0;
      start_reg <= 1'b0;
      cnt_reg   <= '0;
      last_reg  <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rr_reg    <= rr_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      t0_reg    <= t0_next;
      t1_reg    <= t1_next;
      base_reg  <= base_next;
      limit_reg <= limit_next;
      step_reg  <= step_next;
      start_reg <= start_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  assign bus._valid0    = valid_reg[0];
  assign bus._valid1    = valid_reg[1];
  assign bus._0_0       = t0_reg[0];
  assign bus._1_0       = t1_reg[0];
  assign bus._0_1       = t0_reg[1];
  assign bus._1_1       = t1_reg[1];
  assign bus._done0     = done_reg[0];
  assign bus._done1     = done_reg[1];
  assign bus.grant      = grant_reg;
  assign bus.last_beats = last_reg;
  assign bus.hr_base    = base_reg;
  assign bus.hr_limit   = limit_reg;
  assign bus.hr_step    = step_reg;
  assign bus.hr_start   = start_reg;
  assign bus.hr_ready   = hr_ready_int;
  assign bus.hr_reset   = _reset;
endmodule

// File: tb/tb_hrange_share_arbiter.sv
// tb_hrange_share_arbiter
//   Directed bench for hrange_share_arbiter. A small hrange model produces
//   tuples (value, index) for range(base, limit, step). Single sessions come
//   from a vector table. Contention, fairness and mid-stream reset are
//   separate hand-written sequences. CNT_W is 3 so the counter saturates.
module tb_hrange_share_arbiter;
  localparam int WIDTH = 32;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hrange_share_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  hrange_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    ._clock(clk),
    ._reset(rst),
    .bus   (bus)
  );

  // ---------------- hrange model ----------------
  logic signed [WIDTH-1:0] m_cur = '0, m_limit = '0, m_step = '0;
  int   m_idx = 0;
  logic m_active = 1'b0;
  logic force_both = 1'b0;   // assert hr_valid together with hr_done at the end
  logic m_more;
  assign m_more       = m_cur < m_limit;
  assign bus.hr_0     = m_cur;
  assign bus.hr_1     = WIDTH'(m_idx);
  assign bus.hr_valid = m_active && (m_more || force_both);
  assign bus.hr_done  = m_active && !m_more;

  always @(posedge clk) begin
    if (bus.hr_reset) begin
      m_active <= 1'b0;
    end else if (bus.hr_start) begin
      m_cur    <= bus.hr_base;
      m_limit  <= bus.hr_limit;
      m_step   <= bus.hr_step;
      m_idx    <= 0;
      m_active <= 1'b1;
    end else if (bus.hr_done) begin
      m_active <= 1'b0;
    end else if (bus.hr_valid && bus.hr_ready) begin
      m_cur <= m_cur + m_step;
      m_idx <= m_idx + 1;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  logic signed [WIDTH-1:0] qv0[$], qv1[$], qi0[$], qi1[$];
  int done_cnt[2] = '{0, 0};
  int start_cnt = 0;
  int order[$];

  // Monitor on the falling edge. Inputs change only just after rising edges.
  initial begin
    logic [1:0] vld, rdy, dn, pv_valid, pv_ready, pv_done;
    logic signed [WIDTH-1:0] d0[2], d1[2], pv_d0[2], pv_d1[2];
    pv_valid = 2'b00; pv_ready = 2'b00; pv_done = 2'b00;
    pv_d0 = '{0, 0}; pv_d1 = '{0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        pv_valid = 2'b00;
        pv_done  = 2'b00;
      end else begin
        vld = {bus._valid1, bus._valid0};
        rdy = {bus._ready1, bus._ready0};
        dn  = {bus._done1, bus._done0};
        d0[0] = bus._0_0; d1[0] = bus._1_0;
        d0[1] = bus._0_1; d1[1] = bus._1_1;
        for (int n = 0; n < 2; n++) begin
          chk("valid_without_grant", vld[n] & ~bus.grant[n], 0);
          if (pv_valid[n] && !pv_ready[n]) begin
            chk("hold_valid", vld[n], 1);
            chk("hold_data0", d0[n], pv_d0[n]);
            chk("hold_data1", d1[n], pv_d1[n]);
          end
          if (vld[n] && !rdy[n]) chk("hr_ready_when_full", bus.hr_ready, 0);
          if (pv_done[n]) chk("done_one_cycle", dn[n], 0);
          if (dn[n]) begin
            chk("done_with_valid", vld[n], 0);
            done_cnt[n]++;
            order.push_back(n);
          end
          if (vld[n] && rdy[n]) begin
            if (n == 0) begin qv0.push_back(d0[0]); qi0.push_back(d1[0]); end
            else        begin qv1.push_back(d0[1]); qi1.push_back(d1[1]); end
          end
        end
        if (bus.hr_start) start_cnt++;
        pv_valid = vld; pv_ready = rdy; pv_done = dn;
        pv_d0 = d0; pv_d1 = d1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    int client;
    int base;
    int limit;
    int step;
    bit toggle;      // toggle the client's ready every cycle
    bit both;        // hrange also asserts hr_valid with hr_done
    int exp_beats;
    int exp_last;    // expected last_beats (saturates at 7)
  } vec_t;

  task automatic set_args(input int c, input int b, input int l, input int s);
    if (c == 0) begin bus.base0 = b; bus.limit0 = l; bus.step0 = s; end
    else        begin bus.base1 = b; bus.limit1 = l; bus.step1 = s; end
  endtask

  task automatic set_req(input int c, input logic v);
    if (c == 0) bus.req0 = v; else bus.req1 = v;
  endtask

  task automatic clear_q();
    qv0.delete(); qv1.delete(); qi0.delete(); qi1.delete(); order.delete();
  endtask

  task automatic check_beats(input int c, input int b, input int s, input int n);
    if (c == 0) begin
      chk("beat_count0", qv0.size(), n);
      for (int i = 0; i < n && i < qv0.size(); i++) begin
        chk("beat_val0", qv0[i], b + s * i);
        chk("beat_idx0", qi0[i], i);
      end
    end else begin
      chk("beat_count1", qv1.size(), n);
      for (int i = 0; i < n && i < qv1.size(); i++) begin
        chk("beat_val1", qv1[i], b + s * i);
        chk("beat_idx1", qi1[i], i);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int d0, s0, cyc;
    bit seen;
    clear_q();
    d0 = done_cnt[v.client];
    s0 = start_cnt;
    force_both = v.both;
    bus._ready0 = 1'b1; bus._ready1 = 1'b1;
    set_args(v.client, v.base, v.limit, v.step);
    set_req(v.client, 1'b1);
    @(posedge clk); #1;
    chk("grant_onehot", bus.grant, 1 << v.client);
    chk("start_latency", bus.hr_start, 1);
    set_req(v.client, 1'b0);
    seen = 0;
    for (cyc = 0; cyc < 300 && !seen; cyc++) begin
      @(posedge clk); #1;
      if (v.toggle) begin
        if (v.client == 0) bus._ready0 = ~bus._ready0;
        else               bus._ready1 = ~bus._ready1;
      end
      if (done_cnt[v.client] > d0) seen = 1;
    end
    if (!seen) chk("session_timeout", 0, 1);
    bus._ready0 = 1'b1; bus._ready1 = 1'b1;
    force_both = 1'b0;
    check_beats(v.client, v.base, v.step, v.exp_beats);
    chk("last_beats", bus.last_beats, v.exp_last);
    chk("grant_idle", bus.grant, 0);
    chk("start_pulses", start_cnt - s0, 1);
    chk("done_pulses", done_cnt[v.client] - d0, 1);
  endtask

  task automatic wait_dones(input int total, input int max_cyc);
    int base;
    base = done_cnt[0] + done_cnt[1];
    for (int i = 0; i < max_cyc; i++) begin
      if (done_cnt[0] + done_cnt[1] - base >= total) return;
      @(posedge clk); #1;
    end
    chk("dones_timeout", done_cnt[0] + done_cnt[1] - base, total);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t vecs[6];

  initial begin
    int s0, dsnap, cyc;
    vecs[0] = '{0,  0, 10, 2, 1'b0, 1'b0,  5, 5};  // basic session
    vecs[1] = '{1,  0,  6, 1, 1'b1, 1'b0,  6, 6};  // backpressure
    vecs[2] = '{0,  5,  5, 1, 1'b0, 1'b0,  0, 0};  // empty range
    vecs[3] = '{1, -3,  3, 2, 1'b0, 1'b0,  3, 3};  // negative values
    vecs[4] = '{0,  0, 10, 1, 1'b0, 1'b0, 10, 7};  // counter saturates
    vecs[5] = '{1,  0,  3, 1, 1'b0, 1'b1,  3, 3};  // beat with hr_done dropped

    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus._ready0 = 1'b1; bus._ready1 = 1'b1;
    set_args(0, 0, 0, 0);
    set_args(1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_valid", {bus._valid1, bus._valid0}, 0);
    chk("rst_done", {bus._done1, bus._done0}, 0);
    chk("rst_hr_start", bus.hr_start, 0);
    chk("rst_hr_ready", bus.hr_ready, 0);
    chk("rst_last_beats", bus.last_beats, 0);
    chk("rst_tuple", bus._0_0, 0);
    chk("rst_hr_reset_hi", bus.hr_reset, 1);
    rst = 1'b0;
    #1;
    chk("rst_hr_reset_lo", bus.hr_reset, 0);

    // Table-driven single sessions.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      $display("vector %0d: client %0d range(%0d,%0d,%0d) beats=%0d last_beats=%0d",
               i, vecs[i].client, vecs[i].base, vecs[i].limit, vecs[i].step,
               (vecs[i].client == 0) ? qv0.size() : qv1.size(), bus.last_beats);
    end

    // Contention: both clients request straight out of reset.
    rst = 1'b1;
    @(posedge clk); #1;
    clear_q();
    s0 = start_cnt;
    set_args(0, 0, 4, 1);
    set_args(1, 10, 13, 1);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    rst = 1'b0;
    wait_dones(2, 200);
    chk("contend_first", order.size() > 0 ? order[0] : -1, 0);
    chk("contend_second", order.size() > 1 ? order[1] : -1, 1);
    chk("contend_starts", start_cnt - s0, 2);
    check_beats(0, 0, 1, 4);
    check_beats(1, 10, 1, 3);
    $display("contention: order %0d,%0d beats %0d/%0d",
             order.size() > 0 ? order[0] : -1, order.size() > 1 ? order[1] : -1,
             qv0.size(), qv1.size());
    do_reset();

    // Fairness: both requests held across four sessions.
    clear_q();
    set_args(0, 0, 2, 1);
    set_args(1, 0, 1, 1);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    wait_dones(4, 300);
    for (int i = 0; i < 4; i++)
      chk("fair_order", order.size() > i ? order[i] : -1, i % 2);
    $display("fairness: %0d sessions observed", order.size());
    do_reset();

    // Reset in the middle of a stream.
    clear_q();
    set_args(0, 0, 10, 1);
    bus.req0 = 1'b1;
    @(posedge clk); #1;
    chk("mid_grant", bus.grant, 1);
    bus.req0 = 1'b0;
    for (cyc = 0; cyc < 100 && qv0.size() < 2; cyc++) begin
      @(posedge clk); #1;
    end
    chk("mid_two_beats", qv0.size() >= 2, 1);
    dsnap = done_cnt[0];
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_valid", {bus._valid1, bus._valid0}, 0);
    chk("mid_grant_clr", bus.grant, 0);
    chk("mid_hr_start", bus.hr_start, 0);
    chk("mid_hr_ready", bus.hr_ready, 0);
    chk("mid_tuple", bus._0_0, 0);
    chk("mid_last_beats", bus.last_beats, 0);
    chk("mid_hr_reset", bus.hr_reset, 1);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_no_done", done_cnt[0] - dsnap, 0);
    $display("mid-stream reset: done pulses after reset %0d", done_cnt[0] - dsnap);
    run_vec('{1, 0, 3, 1, 1'b0, 1'b0, 3, 3});
    $display("post-reset session: client 1 beats=%0d", qv1.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hrange_share_arbiter.md
Name: hrange_share_arbiter

Overview:
- Shares one externally instantiated hrange generator between two requesting generator modules (clients 0 and 1).
- Arbitrates sessions round-robin, launches hrange with the granted client's arguments, and forwards its (_0, _1) tuples to that client through a registered ready/valid slot.
- Ends each session with a one-cycle done pulse to the owner.
- Sits between compiled caller FSMs and a single hrange instance, replacing one hrange instance per caller.

Parameters:
- WIDTH, 32, width of base/limit/step arguments and of tuple elements (signed, passed through unmodified).
- CNT_W, 16, width of the per-session beat counter.

Ports:
- _clock  input  1  clock for sync
- _reset  input  1  synchronous active-high reset
- req0, req1  input  1  client n requests a session (level)
- base0/limit0/step0, base1/limit1/step1  input  WIDTH each  client n hrange arguments, sampled at grant
- _ready0, _ready1  input  1  client n ready for output
- _valid0, _valid1  output  1  client n output tuple valid
- _0_0, _1_0, _0_1, _1_1  output  WIDTH each  tuple elements to client n
- _done0, _done1  output  1  one-cycle pulse, client n session complete
- grant  output  2  one-hot session owner, 0 when idle
- last_beats  output  CNT_W  data beats delivered in the most recent completed session
- hr_base, hr_limit, hr_step  output  WIDTH each  hrange arguments
- hr_start, hr_ready, hr_reset  output  1 each  hrange control
- hr_0, hr_1  input  WIDTH each  hrange tuple
- hr_valid, hr_done  input  1 each  hrange status

Behaviour:
- Reset (sync, high):
  - state IDLE; rr pointer favours client 0.
  - All _valid*, _done*, grant, hr_start, hr_ready = 0.
  - last_beats = 0; tuple regs = 0.
  - hr_reset = _reset, combinational pass-through.
  - Reset mid-session abandons the session: no done pulse, no data delivered.
- States: IDLE, LAUNCH, STREAM, FINISH.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the client not served last; after reset, client 0 wins.
  - On grant: register arguments into hr_*, set grant, hr_start<=1, go to LAUNCH. hr_done is ignored in IDLE.
- LAUNCH (1 cycle): hr_start high, hr_ready=0, hr_done ignored; clear the beat counter; next STREAM with hr_start<=0.
- STREAM:
  - hr_ready = grant active && (!_valid_g || _ready_g), combinational; g is the granted client.
  - Data beat: hr_valid && hr_ready && !hr_done. Capture hr_0/hr_1 into client g's tuple regs, set _valid_g, increment the beat counter (saturating at 2^CNT_W-1).
  - hr_done high ends the session. Any beat with hr_done in the same cycle is discarded. Go to FINISH.
- FINISH:
  - hr_ready=0.
  - Wait until client g's slot is empty, or is drained this cycle (_ready_g high).
  - Then pulse _done_g for 1 cycle, copy the beat counter to last_beats, set rr pointer to g, clear grant, go to IDLE.
  - _done_g is never high in the same cycle as _valid_g.
- Client handshake:
  - _valid_n holds with stable data until _ready_n is sampled high.
  - _ready of the non-granted client is ignored.
  - Non-granted client outputs stay 0/invalid.
- Dropping req mid-session has no effect; the session runs to hr_done.
- req still high after done is re-arbitrated normally. With the other client requesting, the other client wins.
- Latency: req high at edge t gives hr_start high in cycle t+1. A beat accepted from hrange at edge k is visible on _valid_g in cycle k+1. Throughput is 1 beat/cycle with _ready_g held high.
- No arithmetic on tuple data; widths pass through.

Test Plan:
- Single session: req0 with (0,10,2), _ready0 high → 5 beats on _0_0 = 0,2,4,6,8 (tuples match the Python hrange golden), then _done0 one pulse; last_beats=5; grant returns to 0.
- Contention: req0 and req1 both high from reset, args (0,4,1) and (10,13,1) → client 0 session (4 beats) completes, then client 1 (3 beats); hr_start pulses twice; no interleaving.
- Backpressure: toggle _ready1 every other cycle on (0,6,1) → no beat lost or duplicated; _valid1 data stable while _ready1 low; hr_ready low whenever the slot is full and not draining.
- Empty range: req0 with (5,5,1) → zero beats, _done0 pulses, last_beats=0, _valid0 never high.
- Reset mid-stream: _reset after 2 beats of (0,10,1) → all outputs 0 next cycle, no _done0. A following req1 with (0,3,1) delivers exactly 3 beats.
- Fairness: req0 held high continuously, req1 high → grants alternate 0,1,0,1 across four sessions.
